array_heap: RTL and testbench

ARRAY_HEAP -- requirements
Module: array_heap

---
 rtl/array_heap.sv | 233 +++++++++++++++++++++++
 tb/tb_array_heap.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/array_heap.sv
// Small heap of fixed-length arrays with alloc/free, element access and
// multi-cycle scans (index-of, count-less, count-greater).
module array_heap #(
  parameter int unsigned ADDRESS_BITS = 2,
  parameter int unsigned INDEX_BITS   = 1,
  parameter int unsigned DATA_BITS    = 12
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic [7:0]              action,
  input  logic [ADDRESS_BITS-1:0] array,
  input  logic [INDEX_BITS-1:0]   index,
  input  logic [DATA_BITS-1:0]    in,
  output logic [DATA_BITS-1:0]    out,
  output logic [31:0]             error,
  output logic                    busy,
  output logic                    done
);
  localparam int unsigned ARRAYS = 2 ** ADDRESS_BITS;
  localparam int unsigned LEN    = 2 ** INDEX_BITS;
  localparam int unsigned SB     = INDEX_BITS + 1;
  localparam int unsigned PB     = ADDRESS_BITS + 1;

  localparam logic [7:0] A_RESET = 8'd1,  A_WRITE = 8'd2,  A_READ    = 8'd3;
  localparam logic [7:0] A_SIZE  = 8'd4,  A_INDEX = 8'd7,  A_LESS    = 8'd8;
  localparam logic [7:0] A_GREATER = 8'd9, A_PUSH = 8'd14, A_POP     = 8'd15;
  localparam logic [7:0] A_ALLOC = 8'd18, A_FREE  = 8'd19, A_ADD     = 8'd20;

  localparam logic [31:0] E_NOT_ALLOC   = 32'd10000010;
  localparam logic [31:0] E_RANGE       = 32'd10000011;
  localparam logic [31:0] E_FULL        = 32'd10000012;
  localparam logic [31:0] E_EMPTY       = 32'd10000013;
  localparam logic [31:0] E_DOUBLE_FREE = 32'd10000014;
  localparam logic [31:0] E_ALLOC_FULL  = 32'd10000015;
  localparam logic [31:0] E_UNKNOWN     = 32'd10000016;

  if (DATA_BITS <= INDEX_BITS) begin : g_bad_width
    $error("array_heap: DATA_BITS must exceed INDEX_BITS");
  end

  typedef enum logic [1:0] {IDLE, SCAN, FINISH} state_t;
  state_t state_q, state_d;

  logic [DATA_BITS-1:0]    mem     [ARRAYS][LEN];
  logic [SB-1:0]           size_q  [ARRAYS];
  logic [ADDRESS_BITS-1:0] stack_q [ARRAYS];
  logic [ARRAYS-1:0]       alloc_q;
  logic [PB-1:0]           sp_q, next_q;

  logic [7:0]              act_q;
  logic [ADDRESS_BITS-1:0] arr_q;
  logic [DATA_BITS-1:0]    in_q;
  logic [INDEX_BITS-1:0]   cnt_q;
  logic [SB-1:0]           acc_q, acc_d;
  logic                    found_q, found_d;

  logic [DATA_BITS-1:0]    out_d, mem_wd;
  logic [31:0]             err_d;
  logic                    done_d, mem_we, size_we, alloc_we, alloc_wd;
  logic                    push_stk, pop_stk, next_inc, clear_all;
  logic [ADDRESS_BITS-1:0] mem_wa, size_wa, alloc_wa;
  logic [INDEX_BITS-1:0]   mem_wi;
  logic [SB-1:0]           size_wd;

  logic [SB-1:0]           cur_sz;
  logic [DATA_BITS-1:0]    cur_elem, top_elem, scan_elem;
  logic                    cur_alloc, alloc_full, is_scan, scan_valid, scan_last;
  logic [ADDRESS_BITS-1:0] pick;

  assign cur_sz     = size_q[array];
  assign cur_alloc  = alloc_q[array];
  assign cur_elem   = mem[array][index];
  assign top_elem   = mem[array][INDEX_BITS'(cur_sz - SB'(1))];
  assign alloc_full = (sp_q == '0) && (next_q == PB'(ARRAYS));
  assign pick       = (sp_q != '0) ? stack_q[ADDRESS_BITS'(sp_q - PB'(1))]
                                   : next_q[ADDRESS_BITS-1:0];
  assign is_scan    = (action == A_INDEX) || (action == A_LESS) || (action == A_GREATER);
  assign scan_elem  = mem[arr_q][cnt_q];
  assign scan_valid = {1'b0, cnt_q} < size_q[arr_q];
  assign scan_last  = cnt_q == INDEX_BITS'(LEN - 1);

  always_ff @(posedge clock) begin : state_reg
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin : next_state
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = is_scan ? SCAN : FINISH;
      SCAN:    if (scan_last) state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Results and storage updates; single-step ops resolve in the start cycle.
  always_comb begin : outputs
    out_d = out;      err_d = error;    done_d = 1'b0;
    acc_d = acc_q;    found_d = found_q;
    mem_we = 1'b0;    mem_wa = '0;      mem_wi = '0;     mem_wd = '0;
    size_we = 1'b0;   size_wa = '0;     size_wd = '0;
    alloc_we = 1'b0;  alloc_wa = '0;    alloc_wd = 1'b0;
    push_stk = 1'b0;  pop_stk = 1'b0;   next_inc = 1'b0; clear_all = 1'b0;
    if (state_q == IDLE && start && !is_scan) begin
      done_d = 1'b1;
      out_d  = '0;
      err_d  = '0;
      case (action)
        A_RESET: clear_all = 1'b1;
        A_ALLOC:
          if (alloc_full) err_d = E_ALLOC_FULL;
          else begin
            alloc_we = 1'b1; alloc_wa = pick; alloc_wd = 1'b1;
            size_we  = 1'b1; size_wa  = pick; size_wd  = '0;
            pop_stk  = sp_q != '0;
            next_inc = sp_q == '0;
            out_d    = DATA_BITS'(pick);
          end
        A_FREE:
          if (!cur_alloc) err_d = E_DOUBLE_FREE;
          else begin
            alloc_we = 1'b1; alloc_wa = array; alloc_wd = 1'b0;
            push_stk = 1'b1;
          end
        A_WRITE, A_READ, A_SIZE, A_PUSH, A_POP, A_ADD:
          if (!cur_alloc) err_d = E_NOT_ALLOC;
          else begin
            case (action)
              A_WRITE: begin
                mem_we = 1'b1; mem_wa = array; mem_wi = index; mem_wd = in;
                if ({1'b0, index} >= cur_sz) begin
                  size_we = 1'b1; size_wa = array; size_wd = {1'b0, index} + SB'(1);
                end
                out_d = in;
              end
              A_READ:
                if ({1'b0, index} >= cur_sz) err_d = E_RANGE;
                else out_d = cur_elem;
              A_SIZE: out_d = DATA_BITS'(cur_sz);
              A_PUSH:
                if (cur_sz == SB'(LEN)) err_d = E_FULL;
                else begin
                  mem_we  = 1'b1; mem_wa = array; mem_wi = cur_sz[INDEX_BITS-1:0]; mem_wd = in;
                  size_we = 1'b1; size_wa = array; size_wd = cur_sz + SB'(1);
                end
              A_POP:
                if (cur_sz == '0) err_d = E_EMPTY;
                else begin
                  size_we = 1'b1; size_wa = array; size_wd = cur_sz - SB'(1);
                  out_d   = top_elem;
                end
              default:
                if ({1'b0, index} >= cur_sz) err_d = E_RANGE;
                else begin
                  mem_we = 1'b1; mem_wa = array; mem_wi = index; mem_wd = cur_elem + in;
                  out_d  = cur_elem + in;
                end
            endcase
          end
        default: err_d = E_UNKNOWN;
      endcase
    end else if (state_q == SCAN) begin
      if (scan_valid) begin
        case (act_q)
          A_LESS:    if (scan_elem < in_q) acc_d = acc_q + SB'(1);
          A_GREATER: if (scan_elem > in_q) acc_d = acc_q + SB'(1);
          default:
            if (!found_q && scan_elem == in_q) begin
              acc_d   = {1'b0, cnt_q} + SB'(1);
              found_d = 1'b1;
            end
        endcase
      end
      if (scan_last) begin
        done_d = 1'b1;
        if (!alloc_q[arr_q]) begin
          out_d = '0;
          err_d = E_NOT_ALLOC;
        end else begin
          out_d = DATA_BITS'(acc_d);
          err_d = '0;
        end
      end
    end
  end

  always_ff @(posedge clock) begin : mem_write
    if (mem_we && !reset) mem[mem_wa][mem_wi] <= mem_wd;
  end

  // Allocation bookkeeping; stack entries above sp_q are don't-care.
  always_ff @(posedge clock) begin : heap_regs
    if (reset || clear_all) begin
      alloc_q <= '0;
      sp_q    <= '0;
      next_q  <= '0;
      for (int i = 0; i < ARRAYS; i++) size_q[i] <= '0;
    end else begin
      if (size_we)  size_q[size_wa]   <= size_wd;
      if (alloc_we) alloc_q[alloc_wa] <= alloc_wd;
      if (push_stk) begin
        stack_q[ADDRESS_BITS'(sp_q)] <= array;
        sp_q <= sp_q + PB'(1);
      end else if (pop_stk) begin
        sp_q <= sp_q - PB'(1);
      end
      if (next_inc) next_q <= next_q + PB'(1);
    end
  end

  always_ff @(posedge clock) begin : result_regs
    if (reset) begin
      out <= '0;   error <= '0;   done <= 1'b0;  busy <= 1'b0;
      act_q <= '0; arr_q <= '0;   in_q <= '0;
      cnt_q <= '0; acc_q <= '0;   found_q <= 1'b0;
    end else begin
      out   <= out_d;
      error <= err_d;
      done  <= done_d;
      busy  <= state_d != IDLE;
      if (state_q == IDLE && start) begin
        act_q <= action; arr_q <= array; in_q <= in;
        cnt_q <= '0;     acc_q <= '0;    found_q <= 1'b0;
      end else if (state_q == SCAN) begin
        cnt_q   <= cnt_q + INDEX_BITS'(1);
        acc_q   <= acc_d;
        found_q <= found_d;
      end
    end
  end
endmodule

// File: tb/tb_array_heap.sv
// Bench for array_heap (2,1,12): directed ops against an abstract heap model,
// checked every cycle by one monitor, with literal expectations pinning the model.
module tb_array_heap;
  localparam int NA = 4, LEN = 2, DMOD = 4096;
  localparam int RST = 1, WR = 2, RD = 3, SZ = 4, IDX = 7, LESS = 8, GRT = 9;
  localparam int PUSH = 14, POP = 15, ALLOC = 18, FREE = 19, ADD = 20;
  localparam int E10 = 10000010, E11 = 10000011, E12 = 10000012, E13 = 10000013;
  localparam int E14 = 10000014, E15 = 10000015, E16 = 10000016;

  logic        clock = 1'b0, reset = 1'b1, start = 1'b0;
  logic [7:0]  action = '0;
  logic [1:0]  array = '0;
  logic [0:0]  index = '0;
  logic [11:0] in = '0;
  logic [11:0] out;
  logic [31:0] error;
  logic        busy, done;

  array_heap #(.ADDRESS_BITS(2), .INDEX_BITS(1), .DATA_BITS(12)) dut (
    .clock(clock), .reset(reset), .start(start), .action(action), .array(array),
    .index(index), .in(in), .out(out), .error(error), .busy(busy), .done(done));

  always #5 clock = ~clock;

  int edge_cnt = 0;
  always @(posedge clock) edge_cnt = edge_cnt + 1;

  // Abstract heap model
  int m_mem [NA][LEN];
  bit m_known [NA][LEN];
  int m_size [NA];
  bit m_alloc [NA];
  int m_free [$];
  int m_next;

  task automatic model_hw_reset();
    for (int a = 0; a < NA; a++) begin
      m_alloc[a] = 0; m_size[a] = 0;
      for (int i = 0; i < LEN; i++) m_known[a][i] = 0;
    end
    m_free.delete();
    m_next = 0;
  endtask

  task automatic model_exec(input int act, input int a, input int idx, input int din,
                            output int eo, output int ee, output bit ec, output int el);
    eo = 0; ee = 0; ec = 1;
    el = (act == IDX || act == LESS || act == GRT) ? LEN + 1 : 1;
    if (act == RST) begin
      for (int k = 0; k < NA; k++) begin m_alloc[k] = 0; m_size[k] = 0; end
      m_free.delete();
      m_next = 0;
    end else if (act == ALLOC) begin
      int p;
      p = -1;
      if (m_free.size() > 0) p = m_free.pop_back();
      else if (m_next < NA) begin p = m_next; m_next++; end
      if (p < 0) ee = E15;
      else begin m_alloc[p] = 1; m_size[p] = 0; eo = p; end
    end else if (act == FREE) begin
      if (!m_alloc[a]) ee = E14;
      else begin m_alloc[a] = 0; m_free.push_back(a); ec = 0; end
    end else if (act inside {WR, RD, SZ, IDX, LESS, GRT, PUSH, POP, ADD}) begin
      if (!m_alloc[a]) ee = E10;
      else begin
        case (act)
          WR: begin
            m_mem[a][idx] = din; m_known[a][idx] = 1;
            if (idx >= m_size[a]) m_size[a] = idx + 1;
            eo = din;
          end
          RD: if (idx >= m_size[a]) ee = E11;
              else begin eo = m_mem[a][idx]; ec = m_known[a][idx]; end
          SZ: eo = m_size[a];
          PUSH: if (m_size[a] == LEN) ee = E12;
                else begin
                  m_mem[a][m_size[a]] = din; m_known[a][m_size[a]] = 1;
                  m_size[a]++; ec = 0;
                end
          POP: if (m_size[a] == 0) ee = E13;
               else begin m_size[a]--; eo = m_mem[a][m_size[a]]; ec = m_known[a][m_size[a]]; end
          ADD: if (idx >= m_size[a]) ee = E11;
               else begin
                 m_mem[a][idx] = (m_mem[a][idx] + din) % DMOD;
                 eo = m_mem[a][idx]; ec = m_known[a][idx];
               end
          default: begin
            int cnt, first;
            cnt = 0; first = 0;
            for (int i = 0; i < m_size[a]; i++) begin
              if (!m_known[a][i]) ec = 0;
              if (act == LESS && m_mem[a][i] < din) cnt++;
              if (act == GRT && m_mem[a][i] > din) cnt++;
              if (act == IDX && first == 0 && m_mem[a][i] == din) first = i + 1;
            end
            eo = (act == IDX) ? first : cnt;
          end
        endcase
      end
    end else ee = E16;
  endtask

  // Driver -> monitor handoff (each variable has one writer)
  int exp_out, exp_err, exp_lat, exp_e0, lit_out, lit_err, lit_lat;
  bit exp_care, exp_lit, abort_win = 0;
  int issued_cnt = 0, tmo_cnt = 0;

  task automatic op(input int act, input int a, input int idx, input int din,
                    input bit lon, input int lout, input int lerr, input int llat, input int hold);
    int eo, ee, el;
    bit ec;
    model_exec(act, a, idx, din, eo, ee, ec, el);
    @(posedge clock); #1;
    exp_out = eo; exp_err = ee; exp_care = ec; exp_lat = el;
    exp_lit = lon; lit_out = lout; lit_err = lerr; lit_lat = llat;
    exp_e0 = edge_cnt + 1;
    action = 8'(act); array = 2'(a); index = 1'(idx); in = 12'(din); start = 1'b1;
    issued_cnt++;
    repeat (1 + hold) @(posedge clock);
    #1 start = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (seen_cnt == issued_cnt) break;
      @(posedge clock); #1;
    end
    if (seen_cnt != issued_cnt) tmo_cnt++;
  endtask

  task automatic abort_scan();
    @(posedge clock); #1;
    abort_win = 1'b1;
    action = 8'(GRT); array = '0; index = '0; in = 12'd4; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0; reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    model_hw_reset();
    repeat (4) @(posedge clock);
    #1 abort_win = 1'b0;
  endtask

  // Monitor: the single compare process
  int tests = 0, fails = 0, seen_cnt = 0, tmo_seen = 0;
  int hold_out = 0, hold_err = 0;
  bit hold_care = 1, rst_prev = 1'b1;

  task automatic chk(input string name, input longint got, input longint want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s at %0t: got %0d, want %0d", name, $time, got, want);
    end
  endtask

  always @(negedge clock) begin
    if (rst_prev) begin
      chk("reset busy", longint'(busy), 0);
      chk("reset done", longint'(done), 0);
      chk("reset out", longint'(out), 0);
      chk("reset error", longint'(error), 0);
      hold_out = 0; hold_err = 0; hold_care = 1;
    end else if (done) begin
      if (issued_cnt == seen_cnt) chk("unexpected done", longint'(done), 0);
      else begin
        chk("error", longint'(error), exp_err);
        if (exp_care) chk("out", longint'(out), exp_out);
        chk("latency", edge_cnt - exp_e0 + 1, exp_lat);
        chk("busy at done", longint'(busy), 1);
        if (exp_lit) begin
          chk("literal out", longint'(out), lit_out);
          chk("literal error", longint'(error), lit_err);
          if (lit_lat != 0) chk("literal latency", edge_cnt - exp_e0 + 1, lit_lat);
        end
        hold_out = exp_out; hold_err = exp_err; hold_care = exp_care;
        seen_cnt++;
      end
    end else begin
      chk("hold error", longint'(error), hold_err);
      if (hold_care) chk("hold out", longint'(out), hold_out);
      if (issued_cnt == seen_cnt && !abort_win) chk("idle busy", longint'(busy), 0);
    end
    if (tmo_cnt != tmo_seen) begin
      chk("done timeout", seen_cnt, issued_cnt);
      tmo_seen++;
      seen_cnt = issued_cnt;
    end
    rst_prev = reset;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_hw_reset();
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    // alloc exhaustion
    op(ALLOC, 0, 0, 0, 1, 0, 0, 1, 0);
    op(ALLOC, 0, 0, 0, 1, 1, 0, 1, 0);
    op(ALLOC, 0, 0, 0, 1, 2, 0, 1, 0);
    op(ALLOC, 0, 0, 0, 1, 3, 0, 1, 0);
    op(ALLOC, 0, 0, 0, 1, 0, E15, 1, 0);
    op(RST, 0, 0, 0, 1, 0, 0, 1, 0);
    // push / pop
    op(ALLOC, 0, 0, 0, 1, 0, 0, 0, 0);
    op(PUSH, 0, 0, 5, 0, 0, 0, 0, 0);
    op(PUSH, 0, 0, 7, 0, 0, 0, 0, 0);
    op(PUSH, 0, 0, 9, 1, 0, E12, 0, 0);
    op(SZ, 0, 0, 0, 1, 2, 0, 0, 0);
    op(POP, 0, 0, 0, 1, 7, 0, 0, 0);
    op(POP, 0, 0, 0, 1, 5, 0, 0, 0);
    op(POP, 0, 0, 0, 1, 0, E13, 0, 0);
    // write / add wrap / read
    op(RST, 0, 0, 0, 1, 0, 0, 0, 0);
    op(ALLOC, 0, 0, 0, 1, 0, 0, 0, 0);
    op(WR, 0, 1, 4095, 1, 4095, 0, 0, 0);
    op(ADD, 0, 1, 2, 1, 1, 0, 0, 0);
    op(SZ, 0, 0, 0, 1, 2, 0, 0, 0);
    op(RD, 0, 1, 0, 1, 1, 0, 0, 0);
    // scans on {3,8}
    op(WR, 0, 0, 3, 1, 3, 0, 0, 0);
    op(WR, 0, 1, 8, 1, 8, 0, 0, 0);
    op(GRT, 0, 0, 4, 1, 1, 0, 3, 0);
    op(LESS, 0, 0, 4, 1, 1, 0, 3, 0);
    op(IDX, 0, 0, 8, 1, 2, 0, 3, 0);
    op(IDX, 0, 0, 6, 1, 0, 0, 3, 0);
    // free stack and error precedence
    op(ALLOC, 0, 0, 0, 1, 1, 0, 0, 0);
    op(FREE, 1, 0, 0, 0, 0, 0, 0, 0);
    op(FREE, 1, 0, 0, 1, 0, E14, 0, 0);
    op(ALLOC, 0, 0, 0, 1, 1, 0, 0, 0);
    op(RD, 3, 0, 0, 1, 0, E10, 0, 0);
    op(RD, 1, 0, 0, 1, 0, E11, 0, 0);
    op(ADD, 1, 0, 1, 1, 0, E11, 0, 0);
    op(5, 0, 0, 0, 1, 0, E16, 0, 0);
    op(PUSH, 2, 0, 1, 1, 0, E10, 0, 0);
    op(LESS, 3, 0, 1, 1, 0, E10, 3, 0);
    // contents survive free/alloc
    op(FREE, 0, 0, 0, 0, 0, 0, 0, 0);
    op(ALLOC, 0, 0, 0, 1, 0, 0, 0, 0);
    op(WR, 0, 1, 100, 1, 100, 0, 0, 0);
    op(RD, 0, 0, 0, 1, 3, 0, 0, 0);
    op(IDX, 0, 0, 3, 1, 1, 0, 3, 0);
    op(PUSH, 0, 0, 1, 1, 0, E12, 0, 0);
    op(WR, 0, 1, 3, 1, 3, 0, 0, 0);
    op(IDX, 0, 0, 3, 1, 1, 0, 3, 0);
    op(GRT, 0, 0, 2, 1, 2, 0, 3, 1);
    op(WR, 1, 0, 50, 1, 50, 0, 0, 0);
    op(LESS, 1, 0, 100, 1, 1, 0, 3, 0);
    op(ADD, 0, 0, 4095, 1, 2, 0, 0, 0);
    // reset aborts a scan
    abort_scan();
    op(SZ, 0, 0, 0, 1, 0, E10, 0, 0);
    op(ALLOC, 0, 0, 0, 1, 0, 0, 0, 0);
    repeat (3) @(posedge clock);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
